seven_seg_capture: RTL

- Receive-side counterpart of the team's hex 7-segment driver.
- Samples the multiplexed, active-low segment and anode lines, qualifies each anode/segment pattern for stability, and decodes the glyph back to a 4-bit value and a 3-bit digit index.
- Assembles all eight digits into a 32-bit frame.
- Used as a display-snoop/self-check block on the board and as a scoreboard front end in simulation.

---
 rtl/seven_seg_capture.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: snoops a multiplexed active-low hex 7-segment display and
// rebuilds each accepted glyph into a digit value/index and a 32-bit frame.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_a,
  input  logic        seg_b,
  input  logic        seg_c,
  input  logic        seg_d,
  input  logic        seg_e,
  input  logic        seg_f,
  input  logic        seg_g,
  input  logic        an_0,
  input  logic        an_1,
  input  logic        an_2,
  input  logic        an_3,
  input  logic        an_4,
  input  logic        an_5,
  input  logic        an_6,
  input  logic        an_7,
  output logic [3:0]  digit_val,
  output logic [2:0]  digit_idx,
  output logic        digit_valid,
  output logic        digit_err,
  output logic [31:0] frame,
  output logic        frame_valid,
  output logic        blank
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;
  // glyph for value i lives in bits [7i+6:7i], gfedcba active-high
  localparam logic [111:0] GLYPHS = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                     7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  state_t      state, state_n;
  logic [14:0] raw, s1, v, prev_v;
  logic [7:0]  cnt, cnt_n, seen, seen_n;
  logic [31:0] buffer, buf_n;
  logic [3:0]  lows, val;
  logic [2:0]  idx;
  logic [6:0]  p;
  logic        an_ok, legal, changed, emit;
  assign raw = {an_7, an_6, an_5, an_4, an_3, an_2, an_1, an_0,
                seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};
  always_comb begin
    lows = '0;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (!v[7+i]) begin
        lows = lows + 4'd1;
        idx = 3'(i);
      end
    an_ok = lows == 4'd1;
    p = ~v[6:0];
    legal = 1'b0;
    val = '0;
    for (int i = 0; i < 16; i++)
      if (GLYPHS[7*i +: 7] == p) begin
        legal = 1'b1;
        val = 4'(i);
      end
    changed = v != prev_v;
    buf_n = buffer;
    buf_n[4*idx +: 4] = val;
    seen_n = seen | (8'd1 << idx);
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    emit = 1'b0;
    if (!an_ok) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (state == IDLE || changed) begin
      state_n = SETTLE;
      cnt_n = '0;
    end else if (state == SETTLE) begin
      if (int'(cnt) + 1 >= STABLE_CYCLES - 1) begin
        state_n = CAPTURED;
        cnt_n = '0;
        emit = 1'b1;
      end else
        cnt_n = cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '1;
      v <= '1;
      prev_v <= '1;
      state <= IDLE;
      cnt <= '0;
      seen <= '0;
      buffer <= '0;
      blank <= 1'b0;
      digit_val <= '0;
      digit_idx <= '0;
      digit_valid <= 1'b0;
      digit_err <= 1'b0;
      frame <= '0;
      frame_valid <= 1'b0;
    end else begin
      s1 <= raw;
      v <= s1;
      prev_v <= v;
      state <= state_n;
      cnt <= cnt_n;
      blank <= !an_ok;
      digit_valid <= emit;
      frame_valid <= 1'b0;
      if (emit) begin
        digit_idx <= idx;
        digit_err <= !legal;
        digit_val <= legal ? val : 4'd0;
        if (legal) begin
          buffer <= buf_n;
          seen <= (seen_n == 8'hFF) ? 8'h00 : seen_n;
          if (seen_n == 8'hFF) begin
            frame <= buf_n;
            frame_valid <= 1'b1;
          end
        end
      end
    end
endmodule
